// File: rtl/halloween_fx_sequencer_if.sv
// Control bundle between the decoration sequencer and the board harness.
// Inputs: en (run switch), prog (4 x 4-bit opcode bank), snd_ack (sound player ack).
// Outputs: color/color_valid, snd_req/snd_code, fx, pc, busy, err.
interface halloween_fx_sequencer_if;
   logic        en;
   logic [15:0] prog;
   logic        snd_ack;
   logic [1:0]  color;
   logic        color_valid;
   logic        snd_req;
   logic [1:0]  snd_code;
   logic [2:0]  fx;
   logic [1:0]  pc;
   logic        busy;
   logic        err;

   // master: harness side, drives the switch, program bank and ack
   modport master (output en, prog, snd_ack,
                   input  color, color_valid, snd_req, snd_code, fx, pc, busy, err);
   // slave: sequencer side
   modport slave  (input  en, prog, snd_ack,
                   output color, color_valid, snd_req, snd_code, fx, pc, busy, err);
endinterface

// File: rtl/halloween_fx_sequencer.sv
// Purpose: fetch/execute sequencer over a 4-slot opcode bank driving color, sound and movement FX.
// Latency: system/color op 2 cycles; sound op waits for snd_ack or SND_TIMEOUT; movement op holds fx DWELL_CYC cycles.
// Backpressure: sound player stalls the program via snd_req/snd_ack; en=0 aborts to IDLE on the next edge.
// Ports: clk, rst (async, active-high), bus (halloween_fx_sequencer_if.slave).
// Option: define SOUND_HANDSHAKE_EN for the ack/timeout handshake; otherwise snd_req is a 1-cycle pulse.
module halloween_fx_sequencer #(
   parameter int DWELL_CYC   = 20,
   parameter int DWELL_W     = 8,
   parameter int SND_TIMEOUT = 255
) (
   input logic                     clk,
   input logic                     rst,
   halloween_fx_sequencer_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_SND_WAIT, S_DWELL} state_t;

   localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYC - 1);
`ifdef SOUND_HANDSHAKE_EN
   localparam logic [DWELL_W-1:0] SND_LOAD = DWELL_W'(SND_TIMEOUT - 1);
`else
   // Ack is meaningless without the handshake.
   logic unused_snd_ack;
   assign unused_snd_ack = bus.snd_ack;
`endif

   state_t             state_q, state_d;
   logic [3:0]         ir_q, ir_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [1:0]         pc_q, pc_d;
   logic [1:0]         color_q, color_d;
   logic               color_valid_q, color_valid_d;
   logic               snd_req_q, snd_req_d;
   logic [1:0]         snd_code_q, snd_code_d;
   logic [2:0]         fx_q, fx_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;

   always_comb begin
      state_d       = state_q;
      ir_d          = ir_q;
      cnt_d         = cnt_q;
      pc_d          = pc_q;
      color_d       = color_q;
      color_valid_d = color_valid_q;
      snd_req_d     = snd_req_q;
      snd_code_d    = snd_code_q;
      fx_d          = fx_q;
      err_d         = err_q;
`ifndef SOUND_HANDSHAKE_EN
      // Without the handshake the request only lives for the cycle after EXEC.
      snd_req_d     = 1'b0;
`endif
      if (!bus.en) begin
         // Switch off wins over any completion this cycle; pc/color/err hold.
         state_d   = S_IDLE;
         snd_req_d = 1'b0;
         fx_d      = 3'b000;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
               ir_d    = bus.prog[{pc_q, 2'b00} +: 4];
               state_d = S_EXEC;
            end
            S_EXEC: begin
               state_d = S_FETCH;
               pc_d    = pc_q + 2'd1;
               case (ir_q[3:2])
                  2'b00: begin
                     if (ir_q[1:0] == 2'b01) begin
                        color_d       = 2'b00;
                        color_valid_d = 1'b0;
                        fx_d          = 3'b000;
                        pc_d          = 2'd0;
                     end else if (ir_q[1]) begin
                        err_d = 1'b1;
                     end
                  end
                  2'b01: begin
                     if (ir_q[1:0] == 2'b11) begin
                        err_d = 1'b1;
                     end else begin
                        color_d       = ir_q[1:0];
                        color_valid_d = 1'b1;
                     end
                  end
                  2'b10: begin
                     if (ir_q[1:0] == 2'b11) begin
                        err_d = 1'b1;
                     end else begin
                        snd_req_d  = 1'b1;
                        snd_code_d = ir_q[1:0];
`ifdef SOUND_HANDSHAKE_EN
                        // pc advances only once the player answers or times out.
                        pc_d    = pc_q;
                        cnt_d   = SND_LOAD;
                        state_d = S_SND_WAIT;
`endif
                     end
                  end
                  default: begin
                     if (ir_q[1:0] == 2'b11) begin
                        err_d = 1'b1;
                     end else begin
                        fx_d    = 3'b001 << ir_q[1:0];
                        cnt_d   = DWELL_LOAD;
                        pc_d    = pc_q;
                        state_d = S_DWELL;
                     end
                  end
               endcase
            end
`ifdef SOUND_HANDSHAKE_EN
            S_SND_WAIT: begin
               if (bus.snd_ack || (cnt_q == '0)) begin
                  snd_req_d = 1'b0;
                  err_d     = err_q | ~bus.snd_ack;
                  pc_d      = pc_q + 2'd1;
                  state_d   = S_FETCH;
               end else begin
                  cnt_d = cnt_q - DWELL_W'(1);
               end
            end
`endif
            S_DWELL: begin
               if (cnt_q == '0) begin
                  fx_d    = 3'b000;
                  pc_d    = pc_q + 2'd1;
                  state_d = S_FETCH;
               end else begin
                  cnt_d = cnt_q - DWELL_W'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         ir_q          <= 4'h0;
         cnt_q         <= '0;
         pc_q          <= 2'd0;
         color_q       <= 2'b00;
         color_valid_q <= 1'b0;
         snd_req_q     <= 1'b0;
         snd_code_q    <= 2'b00;
         fx_q          <= 3'b000;
         busy_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         ir_q          <= ir_d;
         cnt_q         <= cnt_d;
         pc_q          <= pc_d;
         color_q       <= color_d;
         color_valid_q <= color_valid_d;
         snd_req_q     <= snd_req_d;
         snd_code_q    <= snd_code_d;
         fx_q          <= fx_d;
         busy_q        <= busy_d;
         err_q         <= err_d;
      end
   end

   assign bus.color       = color_q;
   assign bus.color_valid = color_valid_q;
   assign bus.snd_req     = snd_req_q;
   assign bus.snd_code    = snd_code_q;
   assign bus.fx          = fx_q;
   assign bus.pc          = pc_q;
   assign bus.busy        = busy_q;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_halloween_fx_sequencer.sv
// Scoreboard bench for halloween_fx_sequencer: directed programs push expected
// pc-retire snapshots, snd_req pulses and fx pulses; a negedge monitor pops and compares.
module tb_halloween_fx_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   halloween_fx_sequencer_if bus ();
   halloween_fx_sequencer #(.DWELL_CYC(20), .DWELL_W(8), .SND_TIMEOUT(255)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct { logic [1:0] pc; logic [1:0] color; logic cv; logic err; int dt; } pc_ev_t;
   typedef struct { int len; logic [1:0] code; } snd_ev_t;
   typedef struct { int len; logic [2:0] val; } fx_ev_t;

   pc_ev_t  exp_pc_q[$];
   snd_ev_t exp_snd_q[$];
   fx_ev_t  exp_fx_q[$];

   int n_vec = 0;
   int n_mis = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name);
      n_vec++;
      n_mis++;
      $display("FAIL %s: actual event seen, required none at %0t", name, $time);
   endtask

   task automatic push_pc(input logic [1:0] pc, input logic [1:0] color, input logic cv,
                          input logic err, input int dt);
      pc_ev_t e;
      e.pc = pc; e.color = color; e.cv = cv; e.err = err; e.dt = dt;
      exp_pc_q.push_back(e);
   endtask

   task automatic push_snd(input int len, input logic [1:0] code);
      snd_ev_t e;
      e.len = len; e.code = code;
      exp_snd_q.push_back(e);
   endtask

   task automatic push_fx(input int len, input logic [2:0] val);
      fx_ev_t e;
      e.len = len; e.val = val;
      exp_fx_q.push_back(e);
   endtask

   // Monitor: detects pc retirements and the end of snd_req / fx pulses.
   int         cyc = 0;
   int         last_pc_cyc = 0;
   logic [1:0] prev_pc = 2'd0;
   int         snd_len = 0;
   logic [1:0] snd_seen = 2'b00;
   int         fx_len = 0;
   logic [2:0] fx_seen = 3'b000;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         prev_pc     = bus.pc;
         last_pc_cyc = cyc;
         snd_len     = 0;
         fx_len      = 0;
      end else begin
         if (bus.pc != prev_pc) begin
            if (exp_pc_q.size() == 0) begin
               unexpected("pc_event");
            end else begin
               pc_ev_t e;
               e = exp_pc_q.pop_front();
               chk("pc_snapshot", {26'd0, bus.pc, bus.color, bus.color_valid, bus.err},
                   {26'd0, e.pc, e.color, e.cv, e.err});
               if (e.dt != 0) chk("pc_spacing", cyc - last_pc_cyc, e.dt);
            end
            prev_pc     = bus.pc;
            last_pc_cyc = cyc;
         end
         if (bus.snd_req) begin
            snd_len++;
            snd_seen = bus.snd_code;
         end else if (snd_len > 0) begin
            if (exp_snd_q.size() == 0) begin
               unexpected("snd_pulse");
            end else begin
               snd_ev_t s;
               s = exp_snd_q.pop_front();
               chk("snd_req_len", snd_len, s.len);
               chk("snd_code", {30'd0, snd_seen}, {30'd0, s.code});
            end
            snd_len = 0;
         end
         if (bus.fx != 3'b000) begin
            fx_len++;
            fx_seen = bus.fx;
         end else if (fx_len > 0) begin
            if (exp_fx_q.size() == 0) begin
               unexpected("fx_pulse");
            end else begin
               fx_ev_t f;
               f = exp_fx_q.pop_front();
               chk("fx_len", fx_len, f.len);
               chk("fx_value", {29'd0, fx_seen}, {29'd0, f.val});
            end
            fx_len = 0;
         end
      end
   end

   function automatic logic [31:0] out_vec();
      return {19'd0, bus.color, bus.color_valid, bus.snd_req, bus.snd_code, bus.fx,
              bus.pc, bus.busy, bus.err};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.en = 1'b0;
      bus.snd_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_values", out_vec(), 32'd0);
      rst = 1'b0;
   endtask

   task automatic wait_snd(input logic level, input int bound);
      for (int i = 0; i < bound && bus.snd_req != level; i++) @(negedge clk);
      chk("snd_req_wait", {31'd0, bus.snd_req}, {31'd0, level});
   endtask

   task automatic wait_fx(input logic active, input int bound);
      for (int i = 0; i < bound && ((bus.fx != 3'b000) != active); i++) @(negedge clk);
      chk("fx_wait", {31'd0, (bus.fx != 3'b000)}, {31'd0, active});
   endtask

   task automatic abort_dwell(input int hold);
      do_reset();
      bus.prog = 16'h000D;
      push_fx(hold, 3'b010);
      bus.en = 1'b1;
      wait_fx(1'b1, 20);
      repeat (hold - 1) @(negedge clk);
      bus.en = 1'b0;
      @(negedge clk);
      // fx off, pc held at 0, idle
      chk("abort_dwell_state", {29'd0, bus.fx, 1'b0} | {30'd0, bus.pc} << 8 | {31'd0, bus.busy},
          32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_err;
      bus.en = 1'b0;
      bus.prog = 16'h0000;
      bus.snd_ack = 1'b0;

      // Color cycling: 00,01,01,10 then wrap to 00, one retire every 2 cycles.
      do_reset();
      bus.prog = 16'h6554;
      push_pc(2'd1, 2'b00, 1'b1, 1'b0, 0);
      push_pc(2'd2, 2'b01, 1'b1, 1'b0, 2);
      push_pc(2'd3, 2'b01, 1'b1, 1'b0, 2);
      push_pc(2'd0, 2'b10, 1'b1, 1'b0, 2);
      push_pc(2'd1, 2'b00, 1'b1, 1'b0, 2);
      bus.en = 1'b1;
      repeat (11) @(negedge clk);
      bus.en = 1'b0;
      repeat (3) @(negedge clk);

      // Sound handshake (or 1-cycle pulse without the handshake).
      do_reset();
      bus.prog = 16'h0008;
`ifdef SOUND_HANDSHAKE_EN
      push_snd(5, 2'b00);
      push_pc(2'd1, 2'b00, 1'b0, 1'b0, 0);
      bus.en = 1'b1;
      wait_snd(1'b1, 20);
      repeat (4) @(negedge clk);
      bus.snd_ack = 1'b1;
      @(negedge clk);
      bus.snd_ack = 1'b0;
      bus.en = 1'b0;
`else
      push_snd(1, 2'b00);
      push_pc(2'd1, 2'b00, 1'b0, 1'b0, 0);
      bus.en = 1'b1;
      wait_snd(1'b1, 20);
      bus.en = 1'b0;
`endif
      repeat (3) @(negedge clk);

      // Sound timeout with ack held low.
      do_reset();
      bus.prog = 16'h0009;
`ifdef SOUND_HANDSHAKE_EN
      exp_err = 1'b1;
      push_snd(255, 2'b01);
`else
      exp_err = 1'b0;
      push_snd(1, 2'b01);
`endif
      push_pc(2'd1, 2'b00, 1'b0, exp_err, 0);
      bus.en = 1'b1;
      wait_snd(1'b1, 20);
      wait_snd(1'b0, 400);
      bus.en = 1'b0;
      repeat (3) @(negedge clk);
      chk("err_after_timeout", {31'd0, bus.err}, {31'd0, exp_err});

      // Dwell: fog for exactly 20 cycles, then pc=1.
      do_reset();
      bus.prog = 16'h000E;
      push_fx(20, 3'b100);
      push_pc(2'd1, 2'b00, 1'b0, 1'b0, 0);
      bus.en = 1'b1;
      wait_fx(1'b1, 20);
      wait_fx(1'b0, 40);
      bus.en = 1'b0;
      repeat (3) @(negedge clk);

      // RESET opcode jumps back to slot 0; reserved slot 3 never runs.
      do_reset();
      bus.prog = 16'h7154;
      push_pc(2'd1, 2'b00, 1'b1, 1'b0, 0);
      push_pc(2'd2, 2'b01, 1'b1, 1'b0, 2);
      push_pc(2'd0, 2'b00, 1'b0, 1'b0, 2);
      push_pc(2'd1, 2'b00, 1'b1, 1'b0, 2);
      bus.en = 1'b1;
      repeat (9) @(negedge clk);
      bus.en = 1'b0;
      repeat (3) @(negedge clk);
      chk("err_reset_prog", {31'd0, bus.err}, 32'd0);

      // Reserved opcode in slot 3 sets sticky err and wraps.
      do_reset();
      bus.prog = 16'h7004;
      push_pc(2'd1, 2'b00, 1'b1, 1'b0, 0);
      push_pc(2'd2, 2'b00, 1'b1, 1'b0, 2);
      push_pc(2'd3, 2'b00, 1'b1, 1'b0, 2);
      push_pc(2'd0, 2'b00, 1'b1, 1'b1, 2);
      push_pc(2'd1, 2'b00, 1'b1, 1'b1, 2);
      bus.en = 1'b1;
      repeat (11) @(negedge clk);
      bus.en = 1'b0;
      repeat (3) @(negedge clk);
      chk("err_sticky_idle", {31'd0, bus.err}, 32'd1);

      // en drop mid-dwell, and exactly on the dwell-expiry cycle (en wins).
      abort_dwell(7);
      abort_dwell(20);

      // Async rst in the middle of a sound wait (or dwell without the handshake).
      do_reset();
`ifdef SOUND_HANDSHAKE_EN
      bus.prog = 16'h0086;
`else
      bus.prog = 16'h00C6;
`endif
      push_pc(2'd1, 2'b10, 1'b1, 1'b0, 0);
      bus.en = 1'b1;
      for (int i = 0; i < 20 && !(bus.snd_req || bus.fx != 3'b000); i++) @(negedge clk);
      chk("op_in_flight", {31'd0, (bus.snd_req || bus.fx != 3'b000)}, 32'd1);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("async_reset_values", out_vec(), 32'd0);
      do_reset();

      chk("pending_pc_events", exp_pc_q.size(), 32'd0);
      chk("pending_snd_events", exp_snd_q.size(), 32'd0);
      chk("pending_fx_events", exp_fx_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule

// File: doc/halloween_fx_sequencer.md
# halloween_fx_sequencer

Program sequencer for the Halloween decoration breadboard. It steps a 2-bit program counter through a four-slot bank of 4-bit opcodes and decodes each opcode. Color opcodes latch a persistent color. Sound opcodes run a request/acknowledge handshake with the sound player. Movement opcodes drive one effect output for a fixed dwell time. It replaces the free-running counter-plus-mux arrangement with a real execute/wait controller.

## Interface
- DWELL_CYC, 20: cycles a movement effect is held (≥1)
- DWELL_W, 8: dwell counter width; DWELL_CYC ≤ 2^DWELL_W
- SND_TIMEOUT, 255: max SND_WAIT cycles before abort (≥1, fits DWELL_W)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  run enable (ON switch); low forces IDLE
- prog  in  16  opcode bank; slot i = prog[4i+3:4i]
- snd_ack  in  1  sound player acknowledge
- color  out  2  00 green, 01 purple, 10 orange
- color_valid  out  1  a color opcode has executed since reset/RESET
- snd_req  out  1  sound request
- snd_code  out  2  00 scream, 01 cackle, 10 boo; valid while snd_req
- fx  out  3  one-hot effect: [0] wave hands, [1] move jaw, [2] fog
- pc  out  2  slot being fetched/executed
- busy  out  1  state ≠ IDLE
- err  out  1  sticky: reserved opcode or sound timeout

## Operation
- Opcode[3:2] selects the class: 00 system, 01 color, 10 sound, 11 movement. Opcode[1:0] selects the operation.
- States: IDLE, FETCH, EXEC, SND_WAIT, DWELL.
- IDLE: entered on reset or when en=0. Leaves to FETCH on the first edge with en=1.
- FETCH: ir ← prog slot pc. prog is sampled only here.
- EXEC decodes ir. All outcomes end with pc ← pc+1 (3 wraps to 0) and a return to FETCH unless noted.
  - 0000 ON: no-op.
  - 0001 RESET: color←00, color_valid←0, fx←0, pc←0. The next fetch is slot 0.
  - 0100/0101/0110: color ← ir[1:0], color_valid←1.
  - 1000/1001/1010: snd_req←1, snd_code←ir[1:0], then go to SND_WAIT. pc does not advance yet.
  - 1100/1101/1110: fx ← one-hot(ir[1:0]), counter ← DWELL_CYC-1, then go to DWELL.
  - 0010, 0011, 0111, 1011, 1111 are reserved: err←1, no other effect.
- SND_WAIT:
  - snd_ack sampled high: snd_req←0, pc++, FETCH.
  - SND_TIMEOUT cycles pass without ack: snd_req←0, err←1, pc++, FETCH.
- DWELL: counter decrements each cycle. At 0: fx←0, pc++, FETCH.
- en=0 in any state: next edge goes to IDLE with snd_req←0 and fx←0. pc, color, color_valid and err hold.
- err clears only on rst.

## Timing
- Reset values: color=00, color_valid=0, snd_req=0, snd_code=00, fx=000, pc=00, busy=0, err=0. State is IDLE.
- All outputs are registered.
- A system or color op takes 2 cycles (FETCH+EXEC). The color update is visible after the EXEC edge.
- Sound: snd_req rises after the EXEC edge. It falls on the edge after snd_ack is sampled high. If snd_ack is already high at the first SND_WAIT cycle, it completes in 1 cycle.
- Movement: fx is high for exactly DWELL_CYC cycles.
- en falling in the same cycle as an ack or dwell expiry: en wins. pc is not advanced.
- rst during any state clears everything immediately, regardless of clk.

## Configuration
- SOUND_HANDSHAKE_EN defined: SND_WAIT handshake and timeout as above.
- SOUND_HANDSHAKE_EN undefined:
  - A sound op asserts snd_req for exactly one cycle after EXEC, with snd_code valid.
  - pc advances and control returns to FETCH. SND_WAIT is never entered.
  - snd_ack is ignored, and timeout errors cannot occur.

## Test plan
- Color cycling: rst, en=1, prog=16'h6554 → color sequence 00,01,01,10, one update every 2 cycles, then wraps to 00. color_valid=1 after the first EXEC; err=0.
- Sound handshake (macro on): prog=16'h0008, snd_ack rises 5 cycles after snd_req → snd_req=1/snd_code=00 for 5 cycles, falls on the next edge, pc=1.
- Timeout: prog=16'h0009, snd_ack held 0 → snd_req drops after 255 cycles, err=1 sticky, pc=1. With the macro off, this gives a 1-cycle snd_req and err=0.
- Dwell: prog=16'h000E, DWELL_CYC=20 → fx=100 for exactly 20 cycles, then 000, then pc=1.
- RESET and reserved opcodes: prog=16'h7154 → slot0 gives color 00. Slot1 gives color 01. Slot2 RESET gives color_valid=0 and the next fetch is slot 0, so slot3 (7, reserved) never executes and err stays 0. Re-run with prog=16'h7004 → slot3 sets err=1 and the wrap to slot 0 follows.
- Abort: drop en mid-DWELL → fx=000 and IDLE next edge, pc held. Assert rst mid-SND_WAIT → snd_req=0 asynchronously, all outputs at reset values.
